// File: rtl/shift_seq_unit.sv
// Multi-cycle shifter: one bit per clock, left or right, with amount clamped to WIDTH.
// Optional macro SHIFT_SEQ_ROTATE_EN adds a rotate input that turns steps into WIDTH-bit rotations.
module shift_seq_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic [2:0]       amt,
    input  logic [WIDTH-1:0] din,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic             rotate,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   dout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_reg;
    logic [WIDTH:0]  work_reg;
    logic [CW-1:0]   count_reg;
    logic            dir_reg;
    logic            busy_reg;
    logic            done_reg;
    logic [WIDTH:0]  dout_reg;
    logic            rot_en;
    logic [CW-1:0]   amt_clamped;
    logic [WIDTH:0]  step_left;
    logic [WIDTH:0]  step_right;
    logic [WIDTH:0]  step_next;

`ifdef SHIFT_SEQ_ROTATE_EN
    logic rot_reg;
    assign rot_en = rot_reg;
`else
    assign rot_en = 1'b0;
`endif

    assign amt_clamped = (int'(amt) > WIDTH) ? CW'(WIDTH) : CW'(amt);

    // Single-position step in each direction; rotation wraps only the low WIDTH bits.
    assign step_left[0]     = rot_en ? work_reg[WIDTH-1] : 1'b0;
    assign step_left[WIDTH] = rot_en ? 1'b0 : work_reg[WIDTH-1];
    assign step_right[WIDTH-1] = rot_en ? work_reg[0] : work_reg[WIDTH];
    assign step_right[WIDTH]   = 1'b0;

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_left
            assign step_left[gi] = work_reg[gi-1];
        end
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_right
            assign step_right[gi] = work_reg[gi+1];
        end
    endgenerate

    assign step_next = dir_reg ? step_right : step_left;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            work_reg  <= '0;
            count_reg <= '0;
            dir_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            dout_reg  <= '0;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        work_reg  <= {1'b0, din};
                        count_reg <= amt_clamped;
                        dir_reg   <= dir;
                        busy_reg  <= 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
                        rot_reg   <= rotate;
`endif
                        state_reg <= (amt_clamped == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    work_reg  <= step_next;
                    count_reg <= count_reg - 1'b1;
                    if (count_reg == CW'(1)) begin
                        // Final step: publish the shifted value in the same edge.
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        dout_reg  <= step_next;
                        busy_reg  <= 1'b0;
                    end
                end
                DONE: begin
                    // A zero-length request arrives here without a pulse yet; emit it first.
                    if (done_reg) begin
                        done_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        done_reg <= 1'b1;
                        dout_reg <= work_reg;
                        busy_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign dout = dout_reg;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Scoreboard bench for shift_seq_unit: expected results queued at issue, checked at done.
// Define SHIFT_SEQ_ROTATE_EN to also exercise the rotate port.
module tb_shift_seq_unit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         dir = 1'b0;
    logic [2:0]   amt = '0;
    logic [W-1:0] din = '0;
    logic         rotate = 1'b0;
    logic         busy;
    logic         done;
    logic [W:0]   dout;

    int n_vec = 0;
    int n_err = 0;
    logic [W:0] exp_q[$];

    shift_seq_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .dir   (dir),
        .amt   (amt),
        .din   (din),
`ifdef SHIFT_SEQ_ROTATE_EN
        .rotate(rotate),
`endif
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] d, input logic dr,
                                         input logic [2:0] a, input logic rt);
        logic [W:0] v;
        int n;
        v = {1'b0, d};
        n = (int'(a) > W) ? W : int'(a);
        for (int i = 0; i < n; i++) begin
            if (rt)
                v = dr ? {1'b0, v[0], v[W-1:1]} : {1'b0, v[W-2:0], v[W-1]};
            else
                v = dr ? {1'b0, v[W:1]} : {v[W-1:0], 1'b0};
        end
        return v;
    endfunction

    // mode 0: plain; 1: extra start while busy; 2: start held during the done cycle
    task automatic run_op(input string tag, input logic [W-1:0] d, input logic dr,
                          input logic [2:0] a, input logic rt, input logic [W:0] expv,
                          input int mode);
        int lat, lat_exp;
        bit got, busy_ok;
        logic [W:0] e, held;
        lat_exp = (int'(a) > W) ? W : int'(a);
        if (lat_exp == 0) lat_exp = 1;
        exp_q.push_back(expv);
        start = 1'b1; din = d; dir = dr; amt = a; rotate = rt;
        @(posedge clk); #1;
        start = 1'b0;
        din = W'($urandom); dir = 1'($urandom); amt = 3'($urandom); rotate = 1'($urandom);
        lat = 0; got = 0; busy_ok = 1;
        while (!got && lat < 20) begin
            if (done) got = 1;
            else begin
                if (!busy) busy_ok = 0;
                if (mode == 1 && lat == 1) begin
                    start = 1'b1; din = 4'hF; amt = 3'd1; dir = 1'b0;
                end else start = 1'b0;
                @(posedge clk); #1;
                lat++;
            end
        end
        start = 1'b0;
        chk({tag, "_busy_hi"}, 32'(busy_ok), 32'd1);
        e = exp_q.pop_front();
        if (!got) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, "_lat"}, lat, lat_exp);
        chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
        chk({tag, "_dout"}, 32'(dout), 32'(e));
        $display("op %s din=%h dir=%0d amt=%0d rot=%0d -> dout=%h lat=%0d", tag, d, dr, a, rt, dout, lat);
        held = dout;
        if (mode == 2) begin
            start = 1'b1; din = 4'h5; amt = 3'd2;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_pulse1"}, 32'(done), 32'd0);
        chk({tag, "_hold"}, 32'(dout), 32'(held));
        if (mode != 0) begin
            repeat (4) begin
                @(posedge clk); #1;
                if (done || busy) chk({tag, "_ignored"}, {30'd0, busy, done}, 32'd0);
            end
            chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
        end
    endtask

    initial begin
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op("l1_B",   4'hB, 1'b0, 3'd1, 1'b0, 5'h16, 0);
        run_op("r1_B",   4'hB, 1'b1, 3'd1, 1'b0, 5'h05, 0);
        run_op("l4_F",   4'hF, 1'b0, 3'd4, 1'b0, 5'h10, 0);
        run_op("r7_F",   4'hF, 1'b1, 3'd7, 1'b0, 5'h00, 0);
        run_op("a0_F",   4'hF, 1'b1, 3'd0, 1'b0, 5'h0F, 0);
        run_op("l5_9",   4'h9, 1'b0, 3'd5, 1'b0, 5'h10, 0);
        run_op("busy_st", 4'h1, 1'b0, 3'd3, 1'b0, 5'h08, 1);
        run_op("done_st", 4'h6, 1'b1, 3'd2, 1'b0, 5'h01, 2);

        // Abort an amt=4 shift two cycles in.
        start = 1'b1; din = 4'hA; dir = 1'b0; amt = 3'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_dout", 32'(dout), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (done) chk("abort_nodone", 32'(done), 32'd0);
        end
        chk("abort_quiet", {30'd0, busy, done}, 32'd0);
        run_op("post_rst", 4'h3, 1'b0, 3'd1, 1'b0, 5'h06, 0);

`ifdef SHIFT_SEQ_ROTATE_EN
        run_op("rol1_B", 4'hB, 1'b0, 3'd1, 1'b1, 5'h07, 0);
        run_op("ror1_B", 4'hB, 1'b1, 3'd1, 1'b1, 5'h0D, 0);
        run_op("rol7_9", 4'h9, 1'b0, 3'd7, 1'b1, 5'h09, 0);
`endif

        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] rd;
            logic rdr, rrt;
            logic [2:0] ra;
            rd = W'($urandom); rdr = 1'($urandom); ra = 3'($urandom);
`ifdef SHIFT_SEQ_ROTATE_EN
            rrt = 1'($urandom);
`else
            rrt = 1'b0;
`endif
            run_op($sformatf("rnd%0d", i), rd, rdr, ra, rrt, model(rd, rdr, ra, rrt), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
